idecode_pipe: RTL and testbench
===============================

# idecode_pipe

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, valid/ready handshaking, a load-use hazard stall, write-back bypass and flush. It sits between the fetch stage and the execute stage of the CPU pipeline. It decodes the fixed instruction format: opcode `[31:28]`, rd `[27:22]`, rs `[21:16]`, rt `[15:10]`, short immediate `[15:0]`, long immediate `[21:0]`. It reads the internal register file and presents registered operands to execute.

## Interface
- `DATA_W`, 32, width of PC, instruction, register data, immediate output.
- `REG_AW`, 6, register address width; the register file has 2^REG_AW entries.
- `IMM_S_W`, 16, short-immediate width (taken from `inst[IMM_S_W-1:0]`).
- `IMM_L_W`, 22, long-immediate width (taken from `inst[IMM_L_W-1:0]`).
- `SIGN_EXT`, 1, 1 = sign-extend immediates to DATA_W, 0 = zero-extend.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: decode accepts this cycle (combinational).
- `pc_in` in DATA_W: PC of the presented instruction.
- `inst_in` in DATA_W: instruction word.
- `svpc_in` in 1: 1 = lhs operand is the PC instead of register rs.
- `wb_en` in 1: register-file write enable.
- `wb_addr` in REG_AW: write address.
- `wb_data` in DATA_W: write data.
- `ex_is_load` in 1: the instruction currently in execute is a load.
- `ex_rd` in REG_AW: destination of that instruction.
- `flush` in 1: discard the held and the incoming instruction.
- `out_valid` out 1: ID/EX register holds a valid instruction.
- `out_ready` in 1: execute accepts this cycle.
- `pc_out`, `lhs`, `rhs`, `imm` out DATA_W: registered PC, operand A, operand B (rt), extended immediate.
- `rd_out` out REG_AW: registered destination.
- `op_out` out 4: registered opcode `inst[31:28]`.

## Operation
- **Register file.** 2^REG_AW × DATA_W. No hardwired-zero register. Writes occur on the clock edge when `wb_en` is high and `rst` is low. On reset, all entries clear to 0.
- **Reads.** Both read ports are combinational with write-through bypass. If `wb_en` is high and `wb_addr` equals a read address, that port returns `wb_data` in the same cycle.
- **Operand selection.**
  - lhs = `svpc_in ? pc_in : R[rs]`.
  - rhs = `R[rt]`.
- **Immediate.**
  - `inst[31]` = 1: imm is the long field.
  - `inst[31]` = 0: imm is the short field.
  - In both cases the field is extended to DATA_W per `SIGN_EXT`, using the field's MSB as the sign.
- **Hazard.** `hazard` is asserted when all of the following hold: `in_valid`, `ex_is_load`, and (`ex_rd` == rs or `ex_rd` == rt). The match is conservative: both fields are compared regardless of opcode.
- **Load enable.** `load_en` = `!out_valid || out_ready`.
- **in_ready** = `!rst && (flush || (load_en && !hazard))`.
- **Register update priority** (clock edge, highest priority first):
  1. `rst`: out_valid←0, all data outputs←0.
  2. `flush`: out_valid←0. The incoming instruction is consumed and dropped; data registers hold.
  3. `load_en && in_valid && !hazard`: capture pc_in, lhs, rhs, imm, rd, op; out_valid←1.
  4. `load_en && (hazard || !in_valid)`: out_valid←0 (bubble); data registers hold.
  5. Otherwise (`out_valid && !out_ready`): hold everything.
- **Flush vs. hazard.** Flush overrides hazard in the same cycle.

## Timing
- **Reset.** All outputs are 0 one edge after `rst` is sampled high, including out_valid, pc_out, lhs, rhs, imm, rd_out and op_out. `in_ready` is 0 while `rst` is high.
- **Latency.** 1 cycle: an instruction accepted at edge N appears with `out_valid`=1 after edge N.
- **Throughput.** With no hazards and `out_ready` held at 1, one instruction per cycle.
- **Load-use stall.** Exactly one bubble per hazard cycle. Fetch must hold `pc_in`/`inst_in` stable while `in_ready`=0.
- **Backpressure.** When `out_ready`=0 and `out_valid`=1, outputs stay stable and `in_ready`=0.
- **Write/read same cycle.** The bypass guarantees that a value written at edge N is visible to an instruction captured at edge N.
- **Reset mid-stall or mid-backpressure.** Reset wins. The pipeline is empty afterwards and no write-back occurs on that edge.

## Test plan
- **Reset then read.** Assert `rst` for 2 cycles with `wb_en`=1 to R5. Then issue an instruction reading rs=5 → lhs=0, out_valid=0 until the first accepted instruction.
- **Bypass.** Set `wb_en`=1, `wb_addr`=7, `wb_data`=0xDEADBEEF. In the same cycle issue an instruction with rs=7, rt=7 → next cycle lhs=rhs=0xDEADBEEF, out_valid=1.
- **Immediates.**
  - inst=0x8020_0000 (bit31=1, long field 0x200000) with SIGN_EXT=1 → imm=0xFFE0_0000.
  - inst=0x0000_8001 → imm=0xFFFF_8001.
  - With SIGN_EXT=0 → imm=0x0000_8001.
- **svpc.** pc_in=0x40, svpc_in=1, R[rs]=0x99 → lhs=0x40, pc_out=0x40.
- **Load-use.** ex_is_load=1, ex_rd=3, incoming rt=3 → in_ready=0, next cycle out_valid=0. Drop ex_is_load → the instruction is captured one cycle later.
- **Backpressure and flush.** Hold out_ready=0 for 3 cycles → outputs are stable and in_ready=0. Then pulse flush with hazard active → in_ready=1, next cycle out_valid=0.

Source files
------------

// File: rtl/idecode_pipe.sv
`timescale 1ns/1ps
// idecode_pipe
// Instruction-decode stage with an integrated ID/EX pipeline register.
// Decodes opcode [31:28], rd [27:22], rs [21:16], rt [15:10], a short
// immediate inst[IMM_S_W-1:0] and a long immediate inst[IMM_L_W-1:0].
// It reads a 2^REG_AW x DATA_W register file that has a write-through
// bypass, and presents registered operands to the execute stage.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   fetch -> decode handshake (in_ready is combinational)
//   pc_in, inst_in        presented PC and instruction word
//   svpc_in               1 = lhs operand is pc_in instead of R[rs]
//   wb_en/addr/data       register-file write port
//   ex_is_load, ex_rd     the instruction in execute, for load-use detection
//   flush                 drop the held instruction and the incoming one
//   out_valid / out_ready decode -> execute handshake
//   pc_out, lhs, rhs, imm, rd_out, op_out   registered ID/EX payload
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high while flushing, since the incoming word is then
// consumed and dropped. Otherwise it is high only when the ID/EX register can
// load (it is empty, or execute takes its content this cycle) and no
// load-use hazard is present. out_valid stays high, with a stable payload,
// until out_ready is seen high.
module idecode_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 6,
  parameter int IMM_S_W  = 16,
  parameter int IMM_L_W  = 22,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] inst_in,
  input  logic              svpc_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] lhs,
  output logic [DATA_W-1:0] rhs,
  output logic [DATA_W-1:0] imm,
  output logic [REG_AW-1:0] rd_out,
  output logic [3:0]        op_out
);

  localparam int NREG = 1 << REG_AW;

  // Field decode
  logic [3:0]        op;
  logic [REG_AW-1:0] rd_f;
  logic [REG_AW-1:0] rs_f;
  logic [REG_AW-1:0] rt_f;

  assign op   = inst_in[31:28];
  assign rd_f = inst_in[22 +: REG_AW];
  assign rs_f = inst_in[16 +: REG_AW];
  assign rt_f = inst_in[10 +: REG_AW];

  // Register file
  logic [DATA_W-1:0] rf_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Combinational reads. The write-through bypass makes a value written on
  // this edge visible to the instruction captured on the same edge.
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  assign rs_data = (wb_en && (wb_addr == rs_f)) ? wb_data : rf_q[rs_f];
  assign rt_data = (wb_en && (wb_addr == rt_f)) ? wb_data : rf_q[rt_f];

  // Immediate extension. The MSB of the selected field is the sign bit;
  // SIGN_EXT=0 forces the extension bits to zero.
  logic              s_sign;
  logic              l_sign;
  logic [DATA_W-1:0] imm_s_ext;
  logic [DATA_W-1:0] imm_l_ext;
  logic [DATA_W-1:0] imm_sel;

  assign s_sign    = SIGN_EXT & inst_in[IMM_S_W-1];
  assign l_sign    = SIGN_EXT & inst_in[IMM_L_W-1];
  assign imm_s_ext = {{(DATA_W-IMM_S_W){s_sign}}, inst_in[IMM_S_W-1:0]};
  assign imm_l_ext = {{(DATA_W-IMM_L_W){l_sign}}, inst_in[IMM_L_W-1:0]};
  assign imm_sel   = inst_in[31] ? imm_l_ext : imm_s_ext;

  // Control. The hazard compare uses rs and rt for every opcode, so it is
  // conservative.
  logic valid_q;
  logic hazard;
  logic load_en;
  logic take;

  assign hazard   = in_valid && ex_is_load && ((ex_rd == rs_f) || (ex_rd == rt_f));
  assign load_en  = !valid_q || out_ready;
  assign take     = load_en && in_valid && !hazard;
  assign in_ready = !rst && (flush || (load_en && !hazard));

  // ID/EX pipeline register
  logic              valid_d;
  logic [DATA_W-1:0] pc_q,  pc_d;
  logic [DATA_W-1:0] lhs_q, lhs_d;
  logic [DATA_W-1:0] rhs_q, rhs_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rd_q,  rd_d;
  logic [3:0]        op_q,  op_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    op_d    = op_q;
    if (flush) begin
      // Flush beats the hazard and the capture; the data registers keep
      // their old contents.
      valid_d = 1'b0;
    end else if (load_en) begin
      // When nothing is captured, a bubble is inserted.
      valid_d = take;
      if (take) begin
        pc_d  = pc_in;
        lhs_d = svpc_in ? pc_in : rs_data;
        rhs_d = rt_data;
        imm_d = imm_sel;
        rd_d  = rd_f;
        op_d  = op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      op_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign lhs       = lhs_q;
  assign rhs       = rhs_q;
  assign imm       = imm_q;
  assign rd_out    = rd_q;
  assign op_out    = op_q;

endmodule

// File: tb/tb_idecode_pipe.sv
`timescale 1ns/1ps
module tb_idecode_pipe;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        svpc_in;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_is_load;
  logic [5:0]  ex_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out, lhs, rhs, imm;
  logic [5:0]  rd_out;
  logic [3:0]  op_out;

  // zero-extending instance, used only for immediate checks
  logic        z_in_ready, z_out_valid;
  logic [31:0] z_pc_out, z_lhs, z_rhs, z_imm;
  logic [5:0]  z_rd_out;
  logic [3:0]  z_op_out;

  idecode_pipe #(.SIGN_EXT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .inst_in(inst_in), .svpc_in(svpc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .lhs(lhs), .rhs(rhs), .imm(imm),
    .rd_out(rd_out), .op_out(op_out)
  );

  idecode_pipe #(.SIGN_EXT(1'b0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .pc_in(pc_in), .inst_in(inst_in), .svpc_in(svpc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .pc_out(z_pc_out), .lhs(z_lhs), .rhs(z_rhs), .imm(z_imm),
    .rd_out(z_rd_out), .op_out(z_op_out)
  );

  // scoreboard and model state
  int checks   = 0;
  int failures = 0;
  logic [137:0] exp_q[$];   // {pc, lhs, rhs, imm, rd, op}
  logic [31:0]  mrf [64];
  bit           model_valid = 1'b0;
  bit           mon_en      = 1'b0;
  bit           exp_ready;
  bit           exp_accept;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                     input logic [5:0] rs, input logic [5:0] rt,
                                     input logic [9:0] lo);
    return {op, rd, rs, rt, lo};
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    if (wb_en && (wb_addr == a)) return wb_data;
    return mrf[a];
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] inst);
    if (inst[31]) return {{10{inst[21]}}, inst[21:0]};
    return {{16{inst[15]}}, inst[15:0]};
  endfunction

  // driver: applies inputs, predicts in_ready / acceptance, pushes expectation
  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit sv, input bit fl, input bit ordy);
    logic [5:0]  rs, rt;
    bit          haz, le;
    logic [31:0] l;
    in_valid  = v;
    pc_in     = pc;
    inst_in   = inst;
    svpc_in   = sv;
    flush     = fl;
    out_ready = ordy;
    rs  = inst[21:16];
    rt  = inst[15:10];
    haz = v && ex_is_load && ((ex_rd == rs) || (ex_rd == rt));
    le  = !model_valid || ordy;
    exp_ready  = !rst && (fl || (le && !haz));
    exp_accept = !rst && !fl && le && v && !haz;
    if (exp_accept) begin
      l = sv ? pc : model_read(rs);
      exp_q.push_back({pc, l, model_read(rt), model_imm(inst), inst[27:22], inst[31:28]});
    end
  endtask

  // advances one edge and updates the model with the inputs seen at that edge
  task automatic tick();
    bit nv, le;
    le = !model_valid || out_ready;
    if (rst) begin
      nv = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 64; i++) mrf[i] = '0;
    end else begin
      if (flush) begin
        nv = 1'b0;
        if (model_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (le) nv = exp_accept;
      else nv = model_valid;
      if (wb_en) mrf[wb_addr] = wb_data;
    end
    @(posedge clk);
    model_valid = nv;
    #1;
  endtask

  // monitor: out_valid against the model, payload against the queue on transfer
  always @(negedge clk) begin
    logic [137:0] e;
    if (mon_en) begin
      checks++;
      if (out_valid !== model_valid) begin
        failures++;
        $display("FAIL out_valid: got %b expected %b", out_valid, model_valid);
      end
      if (model_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: transfer with no expected entry");
        end else begin
          e = exp_q.pop_front();
          if ({pc_out, lhs, rhs, imm, rd_out, op_out} !== e) begin
            failures++;
            $display("FAIL sb_payload: got pc=%h lhs=%h rhs=%h imm=%h rd=%h op=%h expected pc=%h lhs=%h rhs=%h imm=%h rd=%h op=%h",
                     pc_out, lhs, rhs, imm, rd_out, op_out,
                     e[137:106], e[105:74], e[73:42], e[41:10], e[9:4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; wb_en = 1'b1; wb_addr = 6'd5; wb_data = 32'h1234_5678;
    ex_is_load = 1'b0; ex_rd = '0;
    drive(1'b1, 32'h100, mk(4'h1, 6'd2, 6'd5, 6'd6, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    tick();
    tick();
    rst = 1'b0; wb_en = 1'b0;
    checks++;
    if ({out_valid, pc_out, lhs, rhs, imm, rd_out, op_out} !== '0) begin
      failures++;
      $display("FAIL rst_outputs: got v=%b pc=%h lhs=%h rhs=%h imm=%h rd=%h op=%h expected all 0",
               out_valid, pc_out, lhs, rhs, imm, rd_out, op_out);
    end
    mon_en = 1'b1;
    // R5 must read back as 0: the write during reset was suppressed
    drive(1'b1, 32'h100, mk(4'h1, 6'd2, 6'd5, 6'd6, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_read_ready: got %b expected 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || lhs !== 32'h0) begin
      failures++; $display("FAIL rst_read_lhs: got v=%b lhs=%h expected v=1 lhs=00000000", out_valid, lhs);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 6'd7; wb_data = 32'hDEAD_BEEF;
    drive(1'b1, 32'h104, mk(4'h2, 6'd8, 6'd7, 6'd7, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    tick();
    wb_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || lhs !== 32'hDEAD_BEEF || rhs !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass: got v=%b lhs=%h rhs=%h expected v=1 lhs=rhs=deadbeef", out_valid, lhs, rhs);
    end
    // the value must also have been stored
    drive(1'b1, 32'h108, mk(4'h3, 6'd9, 6'd7, 6'd0, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    tick();
    checks++;
    if (lhs !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rf_store: got lhs=%h expected deadbeef", lhs); end
  endtask

  task automatic test_imm();
    drive(1'b1, 32'h10, 32'h8020_0000, 1'b0, 1'b0, 1'b1);
    #1;
    tick();
    checks++;
    if (imm !== 32'hFFE0_0000 || z_imm !== 32'h0020_0000) begin
      failures++; $display("FAIL imm_long: got s=%h z=%h expected s=ffe00000 z=00200000", imm, z_imm);
    end
    drive(1'b1, 32'h14, 32'h0000_8001, 1'b0, 1'b0, 1'b1);
    #1;
    tick();
    checks++;
    if (imm !== 32'hFFFF_8001 || z_imm !== 32'h0000_8001) begin
      failures++; $display("FAIL imm_short: got s=%h z=%h expected s=ffff8001 z=00008001", imm, z_imm);
    end
  endtask

  task automatic test_svpc();
    wb_en = 1'b1; wb_addr = 6'd4; wb_data = 32'h99;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    tick();
    wb_en = 1'b0;
    drive(1'b1, 32'h40, mk(4'h4, 6'd1, 6'd4, 6'd4, 10'h0), 1'b1, 1'b0, 1'b1);
    #1;
    tick();
    checks++;
    if (lhs !== 32'h40 || pc_out !== 32'h40 || rhs !== 32'h99) begin
      failures++; $display("FAIL svpc: got lhs=%h pc=%h rhs=%h expected 40 40 99", lhs, pc_out, rhs);
    end
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_rd = 6'd3;
    drive(1'b1, 32'h300, mk(4'h5, 6'd9, 6'd1, 6'd3, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_ready_rt: got %b expected 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble: got %b expected 0", out_valid); end
    ex_rd = 6'd1;   // rs match stalls too
    drive(1'b1, 32'h300, mk(4'h5, 6'd9, 6'd1, 6'd3, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_ready_rs: got %b expected 0", in_ready); end
    tick();
    ex_is_load = 1'b0;
    drive(1'b1, 32'h300, mk(4'h5, 6'd9, 6'd1, 6'd3, 10'h0), 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_release: got %b expected 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || rd_out !== 6'd9) begin
      failures++; $display("FAIL lu_capture: got v=%b rd=%h expected v=1 rd=09", out_valid, rd_out);
    end
  endtask

  task automatic test_backpressure_flush();
    logic [137:0] a;
    drive(1'b1, 32'h200, mk(4'h6, 6'd10, 6'd4, 6'd7, 10'h3), 1'b0, 1'b0, 1'b1);
    #1;
    tick();
    a = exp_q[exp_q.size()-1];
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h204, mk(4'h7, 6'd11, 6'd12, 6'd13, 10'h0), 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
      checks++;
      if ({pc_out, lhs, rhs, imm, rd_out, op_out} !== a || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_stable[%0d]: got pc=%h lhs=%h v=%b expected pc=%h lhs=%h v=1",
                             i, pc_out, lhs, out_valid, a[137:106], a[105:74]);
      end
      tick();
    end
    ex_is_load = 1'b1; ex_rd = 6'd12;
    drive(1'b1, 32'h204, mk(4'h7, 6'd11, 6'd12, 6'd13, 10'h0), 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    tick();
    flush = 1'b0; ex_is_load = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pc_out !== 32'h200) begin
      failures++; $display("FAIL flush_drop: got v=%b pc=%h expected v=0 pc=00000200", out_valid, pc_out);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, inst;
    bit          sv, need_new;
    need_new = 1'b1;
    pc = 32'h1000; inst = '0; sv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (need_new) begin
        pc   = pc + 32'd4;
        inst = $urandom();
        sv   = ($urandom_range(0, 3) == 0);
      end
      wb_en      = $urandom_range(0, 1);
      wb_addr    = $urandom_range(0, 63);
      wb_data    = $urandom();
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_rd      = ex_is_load ? (($urandom_range(0, 1) == 1) ? inst[15:10] : 6'($urandom_range(0, 63))) : 6'd0;
      drive(1'b1, pc, inst, sv, 1'b0, ($urandom_range(0, 3) != 0));
      #1;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
      end
      need_new = exp_accept;
      tick();
    end
    wb_en = 1'b0; ex_is_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_in = '0; inst_in = '0; svpc_in = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_is_load = 1'b0; ex_rd = '0;
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mrf[i] = '0;
    test_reset();
    test_bypass();
    test_imm();
    test_svpc();
    test_load_use();
    test_backpressure_flush();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
